ks_sub24_pipe: RTL and testbench
================================

# ks_sub24_pipe

Pipelined 24-bit two's-complement subtractor with borrow-in and borrow-out, built as a registered Kogge-Stone prefix network. It is the subtract-direction counterpart to the adder_ks prefix stages. It computes a − b − bin as a + ~b + ~bin, at one operation per cycle. A valid/ready handshake on both sides lets it sit between producer and consumer pipelines with backpressure.

## Interface
- TAG_W, default 4: width of the sideband tag carried alongside each operation.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  input operation present.
- o_ready  out  1  block accepts input this cycle.
- i_a  in  24  minuend.
- i_b  in  24  subtrahend.
- i_bin  in  1  borrow-in.
- i_tag  in  TAG_W  sideband; returned unchanged with the result.
- o_valid  out  1  result present.
- i_ready  in  1  consumer accepts result this cycle.
- o_diff  out  24  (i_a − i_b − i_bin) mod 2^24.
- o_bout  out  1  borrow-out, 1 when unsigned i_a < i_b + i_bin.
- o_tag  out  TAG_W  tag of the operation in o_diff.
- o_ovf  out  1  signed overflow; present only with KS_SUB_OVF_EN.

## Operation
- Accept: an operation is accepted when i_valid && o_ready at a rising edge.
- Seven register stages, each holding a valid bit, the tag, and the stage data.
- S1 (pg):
  - register p = i_a ^ ~i_b and g = i_a & ~i_b, bit-wise;
  - register c0 = ~i_bin;
  - c0 acts as the generate of bit −1.
- S2–S6 (prefix levels, spans 1, 2, 4, 8, 16):
  - at level span s, bit k with k ≥ s: G[k] = G[k] | (P[k] & G[k−s]), P[k] = P[k] & P[k−s];
  - bit k with k < s: grey cell against c0-extended G[k−s], where the index −1 maps to c0; only G is updated;
  - the original p is carried alongside for S7.
- S7 (sum):
  - carry into bit 0 is c0, carry into bit k is G[k−1];
  - o_diff[k] = p[k] ^ carry_k;
  - o_bout = ~G[23].
- Flow control:
  - global advance en = ~o_valid | i_ready, and o_ready = en;
  - when en is 0, every stage holds, including valid bits, data and tags;
  - bubbles are not compressed.
- Ordering: results leave in acceptance order with their own tags.
- Reset:
  - i_rst_n low at an edge clears every stage valid bit and data register;
  - outputs read 0: o_valid 0, o_diff 0, o_bout 0, o_tag 0, o_ovf 0;
  - in-flight operations are discarded, with no partial or stale result afterwards;
  - o_ready is 1 in the first cycle after reset.
- Invalid stages still clock their data when en is 1; the contents are don't-care, but outputs are only meaningful with o_valid.

## Timing
- Latency: an operation accepted at edge k appears on o_valid/o_diff/o_bout/o_tag after edge k+6, when no stall occurs.
- Each cycle of en = 0 adds one cycle of latency to every in-flight operation.
- Throughput: one operation per cycle while i_ready is held high.
- o_ready is combinational from o_valid and i_ready, with no dependence on i_valid.
- Result hold: outputs stay stable while o_valid && ~i_ready.
- Handoff: the result completes at the edge where o_valid && i_ragged handshake occurs, i.e. when o_valid && i_ready.
- Simultaneous accept and complete in one cycle is legal and required at full rate.
- Critical path: one prefix level, or the S7 XOR, per cycle.

## Configuration
- KS_SUB_OVF_EN defined:
  - adds port o_ovf;
  - o_ovf = carry_into_bit23 ^ carry_out, registered in S7 and aligned with o_diff;
  - o_ovf resets to 0.
- KS_SUB_OVF_EN undefined: port o_ovf and all of its logic are absent; the rest of the behaviour is identical.

## Test plan
- Basic subtract: a=100, b=1, bin=0, i_ready=1 → after 7 cycles o_diff=99, o_bout=0, tag echoed.
- Wrap-around: a=0, b=1, bin=0 → o_diff=0xFFFFFF, o_bout=1.
- Borrow-in: a=5, b=5, bin=1 → o_diff=0xFFFFFF, o_bout=1; with bin=0 → o_diff=0, o_bout=0.
- Signed overflow (KS_SUB_OVF_EN): a=0x800000, b=1 → o_diff=0x7FFFFF, o_ovf=1, o_bout=0; a=0x000001, b=0x000002 → o_ovf=0.
- Backpressure: stream 10 back-to-back ops with tags 0–9 and drop i_ready for 3 cycles once o_valid rises → no loss or duplication, tags 0–9 in order, outputs stable during the stall, o_ready=0 during the stall.
- Reset mid-flight: assert i_rst_n=0 for one edge with 5 ops in flight → o_valid=0 and o_diff=0 next cycle; none of the 5 results ever emerge; a new op completes 7 cycles after acceptance.

Source files
------------

// File: rtl/ks_sub24_pipe.sv
// ks_sub24_pipe: 7-stage registered Kogge-Stone subtractor, o_diff = a - b - bin with valid/ready.
// Optional macro KS_SUB_OVF_EN adds the registered signed-overflow output o_ovf.
module ks_sub24_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [23:0]      i_a,
    input  logic [23:0]      i_b,
    input  logic             i_bin,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [23:0]      o_diff,
    output logic             o_bout,
`ifdef KS_SUB_OVF_EN
    output logic             o_ovf,
`endif
    output logic [TAG_W-1:0] o_tag
);
    logic             vld [1:6];
    logic [TAG_W-1:0] tag [1:6];
    logic [23:0]      pp  [1:6];
    logic [23:0]      gg  [1:6];
    logic [23:0]      p0  [1:6];
    logic             c0  [1:6];
    logic [23:0]      nxt_g [2:6];
    logic [23:0]      nxt_p [2:6];

    assign o_ready = ~o_valid | i_ready;

    // c0 sits at bit -1 with P = 0: the bit at k = s-1 takes a grey cell against it, lower bits are already final
    for (genvar n = 2; n <= 6; n++) begin : g_lvl
        localparam int s = 1 << (n - 2);
        assign nxt_g[n] = gg[n-1] | (pp[n-1] & ((gg[n-1] << s) | (24'(c0[n-1]) << (s - 1))));
        assign nxt_p[n] = pp[n-1] & ((pp[n-1] << s) | ~(24'hffffff << s));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int n = 1; n <= 6; n++) begin
                vld[n] <= 1'b0;
                tag[n] <= '0;
                pp[n]  <= '0;
                gg[n]  <= '0;
                p0[n]  <= '0;
                c0[n]  <= 1'b0;
            end
            o_valid <= 1'b0;
            o_tag   <= '0;
            o_diff  <= '0;
            o_bout  <= 1'b0;
`ifdef KS_SUB_OVF_EN
            o_ovf   <= 1'b0;
`endif
        end else if (o_ready) begin
            vld[1] <= i_valid;
            tag[1] <= i_tag;
            pp[1]  <= i_a ^ ~i_b;
            gg[1]  <= i_a & ~i_b;
            p0[1]  <= i_a ^ ~i_b;
            c0[1]  <= ~i_bin;
            for (int n = 2; n <= 6; n++) begin
                vld[n] <= vld[n-1];
                tag[n] <= tag[n-1];
                pp[n]  <= nxt_p[n];
                gg[n]  <= nxt_g[n];
                p0[n]  <= p0[n-1];
                c0[n]  <= c0[n-1];
            end
            o_valid <= vld[6];
            o_tag   <= tag[6];
            o_diff  <= p0[6] ^ {gg[6][22:0], c0[6]};
            o_bout  <= ~gg[6][23];
`ifdef KS_SUB_OVF_EN
            o_ovf   <= gg[6][22] ^ gg[6][23];
`endif
        end
    end
endmodule

// File: tb/tb_ks_sub24_pipe.sv
// tb_ks_sub24_pipe: random and directed stimulus against an arithmetic reference model with a result queue.
// Build with KS_SUB_OVF_EN defined to also check o_ovf.
module tb_ks_sub24_pipe;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [23:0]      d;
        logic             b;
        logic [TAG_W-1:0] t;
        logic             v;
    } res_t;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [23:0]      i_a = '0;
    logic [23:0]      i_b = '0;
    logic             i_bin = 1'b0;
    logic [TAG_W-1:0] i_tag = '0;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [23:0]      o_diff;
    logic             o_bout;
    logic [TAG_W-1:0] o_tag;
`ifdef KS_SUB_OVF_EN
    logic             o_ovf;
`endif

    int total = 0;
    int bad = 0;
    int n_out = 0;
    res_t q[$];
    res_t prev;
    logic prev_hold = 1'b0;

    ks_sub24_pipe #(.TAG_W(TAG_W)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_a(i_a),
        .i_b(i_b),
        .i_bin(i_bin),
        .i_tag(i_tag),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_diff(o_diff),
        .o_bout(o_bout),
`ifdef KS_SUB_OVF_EN
        .o_ovf(o_ovf),
`endif
        .o_tag(o_tag)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [23:0] a, input logic [23:0] b, input logic bin,
                                   input logic [TAG_W-1:0] t);
        res_t r;
        int s;
        r.d = a - b - 24'(bin);
        r.b = {1'b0, a} < ({1'b0, b} + 25'(bin));
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r.v = (s < -(1 << 23)) || (s > (1 << 23) - 1);
        r.t = t;
        return r;
    endfunction

    function automatic res_t cur();
        res_t r;
        r.d = o_diff;
        r.b = o_bout;
        r.t = o_tag;
`ifdef KS_SUB_OVF_EN
        r.v = o_ovf;
`else
        r.v = 1'b0;
`endif
        return r;
    endfunction

    // Inputs change just after posedge, so the negedge view is what the next edge acts on
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            q.delete();
            prev_hold = 1'b0;
        end else begin
            check("ready_rule", o_ready, !o_valid || i_ready);
            if (prev_hold) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", cur(), prev);
            end
            if (o_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious: got result tag %0h diff %0h want none", o_tag, o_diff);
                end else begin
                    check("diff", o_diff, q[0].d);
                    check("bout", o_bout, q[0].b);
                    check("tag", o_tag, q[0].t);
`ifdef KS_SUB_OVF_EN
                    check("ovf", o_ovf, q[0].v);
`endif
                    if (i_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            prev_hold = o_valid && !i_ready;
            prev = cur();
            if (i_valid && o_ready) q.push_back(model(i_a, i_b, i_bin, i_tag));
        end
    end

    task automatic run_one(input logic [23:0] a, input logic [23:0] b, input logic bin,
                           input logic [TAG_W-1:0] t, input logic [23:0] ed, input logic eb,
                           input logic eo, input string nm);
        res_t m;
        m = model(a, b, bin, t);
        check({nm, "_model_d"}, m.d, ed);
        check({nm, "_model_b"}, m.b, eb);
        check({nm, "_model_v"}, m.v, eo);
        i_a = a; i_b = b; i_bin = bin; i_tag = t; i_valid = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #1 check({nm, "_early"}, o_valid, 0);
        @(posedge i_clk);
        #1;
        check({nm, "_valid"}, o_valid, 1);
        check({nm, "_diff"}, o_diff, ed);
        check({nm, "_bout"}, o_bout, eb);
        check({nm, "_tag"}, o_tag, t);
`ifdef KS_SUB_OVF_EN
        check({nm, "_ovf"}, o_ovf, eo);
`endif
    endtask

    task automatic drain(input string nm);
        int w = 0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        while (q.size() != 0 && w < 100) begin
            @(posedge i_clk);
            #1 w++;
        end
        check({nm, "_drain"}, q.size(), 0);
    endtask

    initial begin
        int n0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        check("rst_valid", o_valid, 0);
        check("rst_diff", o_diff, 0);
        check("rst_bout", o_bout, 0);
        check("rst_tag", o_tag, 0);
        check("rst_ready", o_ready, 1);
`ifdef KS_SUB_OVF_EN
        check("rst_ovf", o_ovf, 0);
`endif

        run_one(24'd100, 24'd1, 1'b0, 4'h3, 24'd99, 1'b0, 1'b0, "basic");
        run_one(24'd0, 24'd1, 1'b0, 4'h5, 24'hffffff, 1'b1, 1'b0, "wrap");
        run_one(24'd5, 24'd5, 1'b1, 4'h6, 24'hffffff, 1'b1, 1'b0, "bin1");
        run_one(24'd5, 24'd5, 1'b0, 4'h9, 24'd0, 1'b0, 1'b0, "bin0");
        run_one(24'h800000, 24'd1, 1'b0, 4'ha, 24'h7fffff, 1'b0, 1'b1, "ovf1");
        run_one(24'h000001, 24'd2, 1'b0, 4'hb, 24'hffffff, 1'b1, 1'b0, "ovf0");
        drain("directed");

        // Ten back-to-back ops with a three-cycle consumer stall once results start
        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    int w = 0;
                    logic acc;
                    i_a = 24'($urandom); i_b = 24'($urandom); i_bin = 1'($urandom);
                    i_tag = TAG_W'(k); i_valid = 1'b1;
                    do begin
                        @(negedge i_clk);
                        acc = o_ready;
                        @(posedge i_clk);
                        #1 w++;
                    end while (!acc && w < 20);
                end
                i_valid = 1'b0;
            end
            begin
                int w = 0;
                while (!o_valid && w < 50) begin
                    @(posedge i_clk);
                    #1 w++;
                end
                check("bp_rise", o_valid, 1);
                i_ready = 1'b0;
                repeat (3) begin
                    @(negedge i_clk);
                    check("bp_ready_low", o_ready, 0);
                    @(posedge i_clk);
                    #1;
                end
                i_ready = 1'b1;
            end
        join
        drain("bp");
        check("bp_count", n_out - n0, 10);

        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 9) < 7);
            i_a = (c % 17 == 0) ? 24'h800000 : 24'($urandom);
            i_b = (c % 13 == 0) ? i_a : 24'($urandom);
            i_bin = 1'($urandom);
            i_tag = TAG_W'($urandom);
            @(posedge i_clk);
            #1;
        end
        drain("rand");

        // Five ops in flight, then a one-edge reset must discard all of them
        n0 = n_out;
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_a = 24'($urandom) | 24'h1; i_b = 24'($urandom); i_bin = 1'b0;
            i_tag = TAG_W'(k + 1); i_valid = 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        check("mid_valid", o_valid, 0);
        check("mid_diff", o_diff, 0);
        check("mid_bout", o_bout, 0);
        check("mid_tag", o_tag, 0);
        check("mid_ready", o_ready, 1);
        repeat (12) @(posedge i_clk);
        #1 check("mid_none", n_out - n0, 0);
        run_one(24'd100, 24'd1, 1'b0, 4'h7, 24'd99, 1'b0, 1'b0, "post_rst");
        drain("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
